// File: rtl/mxv_rx_frame_loader.sv
// rtl/mxv_rx_frame_loader.sv - UART byte-stream frame decoder feeding size, vector and matrix FIFO to MxV
module mxv_rx_frame_loader #(
  parameter int          MAX_N          = 8,
  parameter logic [7:0]  HEADER         = 8'hFE,
  parameter logic [7:0]  TAIL           = 8'hEF,
  parameter int          TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_interrupt,
  input  logic [7:0]           rx_data,
  output logic                 clear_interrupt,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [7:0]           fifo_value,
  output logic [MAX_N*8-1:0]   vector,
  output logic [31:0]          matrix_length,
  output logic                 start,
  output logic                 busy,
  output logic                 frame_error
);

  localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [7:0] CMD_SIZE   = 8'h01;
  localparam logic [7:0] CMD_VECTOR = 8'h02;
  localparam logic [7:0] CMD_MATRIX = 8'h03;
  localparam logic [7:0] CMD_START  = 8'h04;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_TAIL} state_t;

  state_t      state;
  logic        rx_int_d;
  logic [7:0]  cmd_q;
  logic [6:0]  byte_cnt;
  logic [6:0]  idx;
  logic [7:0]  size_shadow;
  logic [7:0]  vec_shadow [MAX_N];
  logic [7:0]  len_q;
  logic [31:0] timer;

  logic        accept;
  logic        timeout;
  logic        cmd_ok;
  logic [6:0]  n7;
  logic [6:0]  pay_len;

  assign accept        = rx_interrupt && !rx_int_d;
  assign busy          = (state != ST_IDLE);
  assign matrix_length = {24'h0, len_q};
  assign n7            = len_q[6:0];
  assign timeout       = (state != ST_IDLE) && !accept && (timer == 32'(TIMEOUT_CYCLES - 1));

  // Payload length decoded straight from the command byte while it is being accepted.
  always_comb begin
    pay_len = 7'd0;
    cmd_ok  = 1'b0;
    case (rx_data)
      CMD_SIZE:   begin pay_len = 7'd1;    cmd_ok = 1'b1;           end
      CMD_VECTOR: begin pay_len = n7;      cmd_ok = (len_q != 8'h0); end
      CMD_MATRIX: begin pay_len = n7 * n7; cmd_ok = (len_q != 8'h0); end
      CMD_START:  begin pay_len = 7'd0;    cmd_ok = (len_q != 8'h0); end
      default:    begin pay_len = 7'd0;    cmd_ok = 1'b0;           end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      rx_int_d        <= 1'b0;
      cmd_q           <= 8'h0;
      byte_cnt        <= 7'd0;
      idx             <= 7'd0;
      size_shadow     <= 8'h0;
      len_q           <= 8'h0;
      timer           <= 32'h0;
      clear_interrupt <= 1'b0;
      fifo_push       <= 1'b0;
      fifo_value      <= 8'h0;
      vector          <= '0;
      start           <= 1'b0;
      frame_error     <= 1'b0;
      for (int i = 0; i < MAX_N; i++) vec_shadow[i] <= 8'h0;
    end else begin
      rx_int_d        <= rx_interrupt;
      clear_interrupt <= accept;
      fifo_push       <= 1'b0;
      start           <= 1'b0;

      if (state == ST_IDLE || accept) timer <= 32'h0;
      else                            timer <= timer + 32'h1;

      if (timeout) begin
        state       <= ST_IDLE;
        frame_error <= 1'b1;
      end else if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == HEADER) begin
              state       <= ST_CMD;
              frame_error <= 1'b0;
            end
          end
          ST_CMD: begin
            cmd_q    <= rx_data;
            byte_cnt <= pay_len;
            idx      <= 7'd0;
            if (!cmd_ok) begin
              frame_error <= 1'b1;
              state       <= ST_IDLE;
            end else if (pay_len == 7'd0) begin
              state <= ST_TAIL;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            case (cmd_q)
              CMD_SIZE:   size_shadow <= rx_data;
              CMD_VECTOR: vec_shadow[idx[IW-1:0]] <= rx_data;
              CMD_MATRIX: begin
                // A full FIFO drops the element but the frame keeps counting.
                if (fifo_full) begin
                  frame_error <= 1'b1;
                end else begin
                  fifo_push  <= 1'b1;
                  fifo_value <= rx_data;
                end
              end
              default: ;
            endcase
            byte_cnt <= byte_cnt - 7'd1;
            idx      <= idx + 7'd1;
            if (byte_cnt == 7'd1) state <= ST_TAIL;
          end
          ST_TAIL: begin
            state <= ST_IDLE;
            if (rx_data != TAIL) begin
              frame_error <= 1'b1;
            end else begin
              case (cmd_q)
                CMD_SIZE: begin
                  if (size_shadow != 8'h0 && size_shadow <= 8'(MAX_N)) len_q <= size_shadow;
                  else                                                 frame_error <= 1'b1;
                end
                CMD_VECTOR: begin
                  for (int i = 0; i < MAX_N; i++)
                    vector[8*i +: 8] <= (i < int'(len_q)) ? vec_shadow[i] : 8'h00;
                end
                CMD_START: start <= 1'b1;
                default: ;
              endcase
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mxv_rx_frame_loader.sv
// tb/tb_mxv_rx_frame_loader.sv - randomized frame-level check of mxv_rx_frame_loader against a reference model
module tb_mxv_rx_frame_loader;

  localparam int         MAX_N  = 8;
  localparam int         TO     = 64;
  localparam logic [7:0] HDR    = 8'hFE;
  localparam logic [7:0] TL     = 8'hEF;

  typedef logic [7:0] byte_q_t[$];

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_interrupt;
  logic [7:0]         rx_data;
  logic               clear_interrupt;
  logic               fifo_full;
  logic               fifo_push;
  logic [7:0]         fifo_value;
  logic [MAX_N*8-1:0] vector;
  logic [31:0]        matrix_length;
  logic               start;
  logic               busy;
  logic               frame_error;

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0, push_cnt = 0, start_cnt = 0;
  int exp_clr = 0, exp_push = 0, exp_start = 0;

  logic [31:0] m_len;
  logic [63:0] m_vec;
  logic        m_err;

  mxv_rx_frame_loader #(.MAX_N(MAX_N), .HEADER(HDR), .TAIL(TL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_interrupt(rx_interrupt), .rx_data(rx_data),
    .clear_interrupt(clear_interrupt), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_value(fifo_value), .vector(vector), .matrix_length(matrix_length),
    .start(start), .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      clr_cnt   += int'(clear_interrupt);
      push_cnt  += int'(fifo_push);
      start_cnt += int'(start);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e_push, input bit e_start);
    @(negedge clk);
    rx_data      = b;
    rx_interrupt = 1'b1;
    @(negedge clk);
    exp_clr++;
    if (e_push) exp_push++;
    if (e_start) exp_start++;
    chk("clear_int", clear_interrupt, 1);
    chk("push", fifo_push, e_push);
    if (e_push) chk("push_val", fifo_value, b);
    chk("start", start, e_start);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_interrupt = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_len = 0;
    m_vec = 0;
    m_err = 0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input byte_q_t pl, input logic [7:0] tb, input bit full);
    int         p;
    logic [7:0] b;
    logic [7:0] sz;
    logic [7:0] vbuf [MAX_N];
    sz = 8'h0;
    fifo_full = full;
    send_byte(HDR, 0, 0);
    m_err = 0;
    chk("hdr_clears_err", frame_error, 0);
    chk("busy_in_frame", busy, 1);
    send_byte(cmd, 0, 0);
    if (cmd < 8'h01 || cmd > 8'h04 || (cmd != 8'h01 && m_len == 0)) begin
      m_err = 1;
    end else begin
      p = (cmd == 8'h01) ? 1 : (cmd == 8'h02) ? int'(m_len) : (cmd == 8'h03) ? int'(m_len * m_len) : 0;
      for (int i = 0; i < p; i++) begin
        b = (i < pl.size()) ? pl[i] : 8'($urandom);
        if (cmd == 8'h01) sz = b;
        if (cmd == 8'h02) vbuf[i] = b;
        if (cmd == 8'h03 && full) m_err = 1;
        send_byte(b, (cmd == 8'h03) && !full, 0);
      end
      send_byte(tb, 0, (tb == TL) && (cmd == 8'h04));
      if (tb != TL) begin
        m_err = 1;
      end else if (cmd == 8'h01) begin
        if (sz >= 1 && sz <= MAX_N) m_len = 32'(sz);
        else                        m_err = 1;
      end else if (cmd == 8'h02) begin
        m_vec = 0;
        for (int k = 0; k < int'(m_len); k++) m_vec[8*k +: 8] = vbuf[k];
      end
    end
    fifo_full = 1'b0;
    chk("matrix_length", matrix_length, m_len);
    chk("vector", vector, m_vec);
    chk("frame_error", frame_error, m_err);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    byte_q_t    q;
    logic [7:0] cmd, tb;
    int         r;
    reset = 1'b1;
    rx_interrupt = 1'b0;
    rx_data = 8'h0;
    fifo_full = 1'b0;
    m_len = 0; m_vec = 0; m_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_len", matrix_length, 0);
    chk("rst_vec", vector, 0);
    chk("rst_err", frame_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_start", start, 0);
    chk("rst_clr", clear_interrupt, 0);
    reset = 1'b0;
    @(negedge clk);

    q = {8'h03}; run_frame(8'h01, q, TL, 0);
    chk("len_is_3", matrix_length, 32'd3);
    q = {8'h0A, 8'h0B, 8'h0C}; run_frame(8'h02, q, TL, 0);
    chk("vec_0c0b0a", vector, 64'h0000_0000_000C_0B0A);
    q = {8'h02}; run_frame(8'h01, q, TL, 0);
    q = {8'h01, 8'h02, 8'h03, 8'h04}; run_frame(8'h03, q, TL, 0);
    q = {}; run_frame(8'h04, q, TL, 0);
    q = {8'h11, 8'h22}; run_frame(8'h02, q, 8'h55, 0);
    chk("bad_tail_err", frame_error, 1);
    q = {8'h09}; run_frame(8'h01, q, TL, 0);
    chk("size9_len_kept", matrix_length, 32'd2);
    q = {8'h01, 8'h02, 8'h03, 8'h04}; run_frame(8'h03, q, TL, 1);

    send_byte(HDR, 0, 0);
    send_byte(8'h01, 0, 0);
    repeat (TO + 10) @(negedge clk);
    m_err = 1;
    chk("timeout_err", frame_error, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_len", matrix_length, m_len);

    do_reset();
    q = {}; run_frame(8'h03, q, TL, 0);
    chk("n0_err", frame_error, 1);

    repeat (40) begin
      r = $urandom_range(0, 19);
      cmd = (r < 4) ? 8'h01 : (r < 9) ? 8'h02 : (r < 15) ? 8'h03 : (r < 18) ? 8'h04 : 8'($urandom_range(5, 255));
      q = {};
      if (cmd == 8'h01) q.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(1, MAX_N)));
      tb = ($urandom_range(0, 9) < 9) ? TL : 8'hA5;
      run_frame(cmd, q, tb, $urandom_range(0, 9) == 0);
    end

    q = {8'h02}; run_frame(8'h01, q, TL, 0);
    send_byte(HDR, 0, 0);
    send_byte(8'h03, 0, 0);
    send_byte(8'h33, 1, 0);
    do_reset();
    chk("midrst_len", matrix_length, 0);
    chk("midrst_vec", vector, 0);
    chk("midrst_err", frame_error, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("midrst_push", fifo_push, 0);
    chk("midrst_start", start, 0);

    chk("clear_count", clr_cnt, exp_clr);
    chk("push_count", push_cnt, exp_push);
    chk("start_count", start_cnt, exp_start);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
